fractal_sync_mp_cnt_rf: RTL and testbench
=========================================

FRACTAL_SYNC_MP_CNT_RF -- requirements
Module: fractal_sync_mp_cnt_rf

Interface
REQ-001 SHALL have parameter N_REGS, default 4, meaning number of counting barrier entries.
REQ-002 SHALL have parameter IDX_WIDTH, default 2, meaning index width, with 2**IDX_WIDTH >= N_REGS checked by a non-synthesis initial assertion.
REQ-003 SHALL have parameter N_PORTS, default 2, meaning number of request ports.
REQ-004 SHALL have parameter CNT_WIDTH, default 4, meaning arrival counter and target width, with 2**CNT_WIDTH > N_PORTS asserted.
REQ-005 SHALL have parameter SD_WIDTH, default 2, meaning source/destination back-routing mask width.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports req_valid_i[N_PORTS] input 1, req_ready_o[N_PORTS] output 1: per-port arrival handshake.
REQ-009 SHALL have ports req_idx_i[N_PORTS] input IDX_WIDTH, req_tgt_i[N_PORTS] input CNT_WIDTH, req_sd_i[N_PORTS] input SD_WIDTH: entry, required arrival count, back-routing mask.
REQ-010 SHALL have ports done_valid_o output 1, done_ready_i input 1, done_idx_o output IDX_WIDTH, done_sd_o output SD_WIDTH: completed-barrier output.
REQ-011 SHALL have ports err_o output 1 (one-cycle pulse) and pending_o output N_REGS (bit i = entry i not IDLE).

Function
REQ-012 SHALL keep per entry: state {IDLE, ARRIVING, FIRED}, cnt, tgt, sd accumulator; IDLE implies cnt=0, sd=0.
REQ-013 SHALL drive req_ready_o[j]=0 iff req_idx_i[j] < N_REGS and that entry is FIRED; otherwise 1, independent of req_valid_i (combinational from state only).
REQ-014 SHALL treat accepted = req_valid_i & req_ready_o; invalid accepted requests (idx >= N_REGS, tgt = 0, or tgt != entry's tgt) SHALL be dropped (not counted, sd not merged) and raise err_o next cycle.
REQ-015 SHALL, for an IDLE entry, latch tgt from the lowest-index accepted port addressing it that cycle; other same-cycle ports with different tgt SHALL be treated as mismatches.
REQ-016 SHALL compute new_cnt = cnt + (number of valid accepted arrivals to the entry) in CNT_WIDTH+1 bits, with no wrap-around.
REQ-017 SHALL OR all valid arriving req_sd_i into the entry sd accumulator (sticky until entry returns to IDLE).
REQ-018 SHALL transition to FIRED when new_cnt >= tgt; to ARRIVING when 0 < new_cnt < tgt; and SHALL pulse err_o if new_cnt > tgt (entry still fires).
REQ-019 SHALL hold a one-entry output register: when !done_valid_o or done_ready_i, load the lowest-index FIRED entry (idx, sd), set done_valid_o, return that entry to IDLE in the same edge.
REQ-020 SHALL clear done_valid_o when done_ready_i is high with no FIRED entry to load.
REQ-021 SHALL keep done_valid_o, done_idx_o and done_sd_o stable while done_valid_o=1 and done_ready_i=0.
REQ-022 SHALL give latency: last arrival accepted at edge t, entry FIRED after t, done_valid_o high after t+1 (2 cycles) when output register free.
REQ-023 SHALL allow an entry freed at edge t to accept a new arrival in the cycle after t (arrivals while FIRED are back-pressured).
REQ-024 SHALL drive done_idx_o and done_sd_o to 0 when done_valid_o=0.
REQ-025 SHALL OR all error conditions of a cycle into a single err_o pulse the following cycle.

Reset
REQ-026 SHALL, while rst_i=1 at an edge, set all entries IDLE (cnt, tgt, sd = 0) and set done_valid_o=0, done_idx_o=0, done_sd_o=0, err_o=0, pending_o=0.
REQ-027 SHALL, on reset mid-operation, discard partial counts and any unconsumed done output without emitting it.

Verification
REQ-028 Port0 idx=1 tgt=2 sd=01 at cycle 0, port1 idx=1 tgt=2 sd=10 at cycle 3 -> pending_o[1]=1 from cycle 1; done_valid_o=1, done_idx_o=1, done_sd_o=11 at cycle 5.
REQ-029 Both ports idx=2 tgt=2 same cycle -> one completion, done_idx_o=2 two cycles later, err_o=0.
REQ-030 done_ready_i=0, entries 0 and 3 fire with tgt=1 -> done_idx_o=0 held stable; req_ready_o=0 for idx 3; after ready, idx 3 presented next cycle.
REQ-031 Entry 0 tgt=3 latched, arrival with tgt=2 -> err_o pulse, cnt unchanged, pending_o[0]=1; idx=5 with N_REGS=4 -> err_o pulse, ready=1.
REQ-032 rst_i=1 with entry ARRIVING and done_valid_o=1 -> next cycle pending_o=0, done_valid_o=0; a fresh tgt=1 arrival completes normally.

Source files
------------

// File: rtl/fractal_sync_mp_cnt_rf.sv
// fractal_sync_mp_cnt_rf
// Multi-port counting barrier register file. Each of N_REGS entries collects
// arrivals from N_PORTS request ports until the required arrival count (tgt,
// latched from the first arrival) is reached. The entry then fires and waits
// for a one-entry output register. Loading it into that register returns the
// entry to IDLE.
//
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   req_valid_i    - per-port arrival valid
//   req_ready_o    - per-port ready (low only when the addressed entry is FIRED)
//   req_idx_i      - per-port entry index
//   req_tgt_i      - per-port required arrival count
//   req_sd_i       - per-port back-routing mask
//   done_valid_o   - completed-barrier valid
//   done_ready_i   - completed-barrier ready
//   done_idx_o     - completed entry index (0 while done_valid_o is low)
//   done_sd_o      - accumulated mask of the completed entry (0 while done_valid_o is low)
//   err_o          - one-cycle pulse, the cycle after any dropped or overshooting arrival
//   pending_o      - bit i set while entry i is not IDLE
module fractal_sync_mp_cnt_rf #(
    parameter int N_REGS    = 4,
    parameter int IDX_WIDTH = 2,
    parameter int N_PORTS   = 2,
    parameter int CNT_WIDTH = 4,
    parameter int SD_WIDTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_PORTS-1:0]   req_valid_i,
    output logic [N_PORTS-1:0]   req_ready_o,
    input  logic [IDX_WIDTH-1:0] req_idx_i [N_PORTS],
    input  logic [CNT_WIDTH-1:0] req_tgt_i [N_PORTS],
    input  logic [SD_WIDTH-1:0]  req_sd_i  [N_PORTS],
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [IDX_WIDTH-1:0] done_idx_o,
    output logic [SD_WIDTH-1:0]  done_sd_o,
    output logic                 err_o,
    output logic [N_REGS-1:0]    pending_o
);

`ifndef SYNTHESIS
    initial begin
        assert ((2 ** IDX_WIDTH) >= N_REGS)
            else $error("IDX_WIDTH too small for N_REGS");
        assert ((2 ** CNT_WIDTH) > N_PORTS)
            else $error("CNT_WIDTH too small for N_PORTS");
    end
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARRIVING = 2'd1,
        FIRED    = 2'd2
    } state_t;

    state_t               st_q  [N_REGS];
    logic [CNT_WIDTH-1:0] cnt_q [N_REGS];
    logic [CNT_WIDTH-1:0] tgt_q [N_REGS];
    logic [SD_WIDTH-1:0]  sd_q  [N_REGS];

    logic [N_PORTS-1:0]   accepted;
    logic [N_PORTS-1:0]   in_range;
    logic [CNT_WIDTH-1:0] tgt_sel  [N_REGS];
    logic [N_REGS-1:0]    tgt_found;
    logic [CNT_WIDTH:0]   add      [N_REGS];
    logic [CNT_WIDTH:0]   new_cnt  [N_REGS];
    logic [SD_WIDTH-1:0]  sd_add   [N_REGS];
    logic                 err_d;

    logic                 fire_any;
    logic [IDX_WIDTH-1:0] fire_idx;
    logic [SD_WIDTH-1:0]  fire_sd;
    logic                 load;

    // Ready depends on entry state only, never on req_valid_i.
    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            in_range[j]    = (32'(req_idx_i[j]) < N_REGS);
            req_ready_o[j] = 1'b1;
            for (int e = 0; e < N_REGS; e++) begin
                if (st_q[e] == FIRED && req_idx_i[j] == IDX_WIDTH'(e)) begin
                    req_ready_o[j] = 1'b0;
                end
            end
        end
        accepted = req_valid_i & req_ready_o;
    end

    // Per-entry arrival accounting. An IDLE entry takes its target from the
    // lowest-index accepted port with a non-zero target; every other arrival
    // must match it or is dropped as an error.
    always_comb begin
        err_d = 1'b0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (accepted[j] && !in_range[j]) begin
                err_d = 1'b1;
            end
        end
        for (int e = 0; e < N_REGS; e++) begin
            tgt_sel[e]   = tgt_q[e];
            tgt_found[e] = 1'b0;
            add[e]       = '0;
            sd_add[e]    = '0;
            if (st_q[e] == IDLE) begin
                tgt_sel[e] = '0;
                for (int j = 0; j < N_PORTS; j++) begin
                    if (!tgt_found[e] && accepted[j] && in_range[j] &&
                        req_idx_i[j] == IDX_WIDTH'(e) && req_tgt_i[j] != '0) begin
                        tgt_found[e] = 1'b1;
                        tgt_sel[e]   = req_tgt_i[j];
                    end
                end
            end
            for (int j = 0; j < N_PORTS; j++) begin
                if (accepted[j] && in_range[j] && req_idx_i[j] == IDX_WIDTH'(e)) begin
                    if (req_tgt_i[j] != '0 && req_tgt_i[j] == tgt_sel[e]) begin
                        add[e]    = add[e] + (CNT_WIDTH+1)'(1);
                        sd_add[e] = sd_add[e] | req_sd_i[j];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            new_cnt[e] = {1'b0, cnt_q[e]} + add[e];
            if (add[e] != '0 && new_cnt[e] > {1'b0, tgt_sel[e]}) begin
                err_d = 1'b1;
            end
        end
    end

    // Lowest-index FIRED entry is the next candidate for the output register.
    always_comb begin
        fire_any = 1'b0;
        fire_idx = '0;
        fire_sd  = '0;
        for (int e = N_REGS - 1; e >= 0; e--) begin
            if (st_q[e] == FIRED) begin
                fire_any = 1'b1;
                fire_idx = IDX_WIDTH'(e);
                fire_sd  = sd_q[e];
            end
        end
        load = !done_valid_o || done_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < N_REGS; e++) begin
                st_q[e]  <= IDLE;
                cnt_q[e] <= '0;
                tgt_q[e] <= '0;
                sd_q[e]  <= '0;
            end
            done_valid_o <= 1'b0;
            done_idx_o   <= '0;
            done_sd_o    <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o <= err_d;
            // FIRED entries never accept (ready is low), so arrivals and the
            // release below never target the same entry in one edge.
            for (int e = 0; e < N_REGS; e++) begin
                if (add[e] != '0) begin
                    tgt_q[e] <= tgt_sel[e];
                    sd_q[e]  <= sd_q[e] | sd_add[e];
                    if (new_cnt[e] >= {1'b0, tgt_sel[e]}) begin
                        st_q[e]  <= FIRED;
                        cnt_q[e] <= tgt_sel[e];
                    end else begin
                        st_q[e]  <= ARRIVING;
                        cnt_q[e] <= new_cnt[e][CNT_WIDTH-1:0];
                    end
                end
                if (load && fire_any && fire_idx == IDX_WIDTH'(e)) begin
                    st_q[e]  <= IDLE;
                    cnt_q[e] <= '0;
                    tgt_q[e] <= '0;
                    sd_q[e]  <= '0;
                end
            end
            if (load) begin
                if (fire_any) begin
                    done_valid_o <= 1'b1;
                    done_idx_o   <= fire_idx;
                    done_sd_o    <= fire_sd;
                end else begin
                    done_valid_o <= 1'b0;
                    done_idx_o   <= '0;
                    done_sd_o    <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < N_REGS; e++) begin
            pending_o[e] = (st_q[e] != IDLE);
        end
    end

endmodule

// File: tb/tb_fractal_sync_mp_cnt_rf.sv
module tb_fractal_sync_mp_cnt_rf;

    localparam int N_REGS    = 4;
    localparam int IDX_WIDTH = 3;
    localparam int N_PORTS   = 2;
    localparam int CNT_WIDTH = 4;
    localparam int SD_WIDTH  = 2;

    logic                 clk;
    logic                 rst;
    logic [N_PORTS-1:0]   req_valid;
    logic [N_PORTS-1:0]   req_ready;
    logic [IDX_WIDTH-1:0] req_idx [N_PORTS];
    logic [CNT_WIDTH-1:0] req_tgt [N_PORTS];
    logic [SD_WIDTH-1:0]  req_sd  [N_PORTS];
    logic                 done_valid;
    logic                 done_ready;
    logic [IDX_WIDTH-1:0] done_idx;
    logic [SD_WIDTH-1:0]  done_sd;
    logic                 err;
    logic [N_REGS-1:0]    pending;

    int vectors = 0;
    int miscompares = 0;

    fractal_sync_mp_cnt_rf #(
        .N_REGS(N_REGS), .IDX_WIDTH(IDX_WIDTH), .N_PORTS(N_PORTS),
        .CNT_WIDTH(CNT_WIDTH), .SD_WIDTH(SD_WIDTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_idx_i(req_idx), .req_tgt_i(req_tgt), .req_sd_i(req_sd),
        .done_valid_o(done_valid), .done_ready_i(done_ready),
        .done_idx_o(done_idx), .done_sd_o(done_sd),
        .err_o(err), .pending_o(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [IDX_WIDTH-1:0] idx,
                            input logic [CNT_WIDTH-1:0] tgt, input logic [SD_WIDTH-1:0] sd);
        req_valid[p] = 1'b1;
        req_idx[p]   = idx;
        req_tgt[p]   = tgt;
        req_sd[p]    = sd;
    endtask

    task automatic clear_req();
        req_valid = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            req_idx[p] = '0;
            req_tgt[p] = '0;
            req_sd[p]  = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        done_ready = 1'b1;
        clear_req();
        step();
        step();
        rst = 1'b0;
        #1;
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
        vectors++; if (done_idx !== 3'd0 || done_sd !== 2'b00) begin miscompares++; $display("FAIL reset_done_data got=%0d/%b exp=0/00", done_idx, done_sd); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
        vectors++; if (req_ready !== 2'b11) begin miscompares++; $display("FAIL reset_ready got=%b exp=11", req_ready); end
    endtask

    task automatic test_two_arrivals();
        // cycle 0
        set_port(0, 3'd1, 4'd2, 2'b01);
        step(); clear_req(); #1; // cycle 1
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL basic_pending_c1 got=%b exp=0010", pending); end
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL basic_noearly got=%b exp=0", done_valid); end
        step(); // cycle 2
        step(); // cycle 3
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL basic_pending_c3 got=%b exp=0010", pending); end
        set_port(1, 3'd1, 4'd2, 2'b10);
        step(); clear_req(); // cycle 4
        req_idx[0] = 3'd1; #1;
        vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL basic_fired_ready got=%b exp=0", req_ready[0]); end
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL basic_c4_valid got=%b exp=0", done_valid); end
        clear_req();
        step(); // cycle 5
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd1 || done_sd !== 2'b11) begin miscompares++; $display("FAIL basic_done got=%b/%0d/%b exp=1/1/11", done_valid, done_idx, done_sd); end
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL basic_freed got=%b exp=0000", pending); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err got=%b exp=0", err); end
        step(); // cycle 6
        vectors++; if (done_valid !== 1'b0 || done_idx !== 3'd0 || done_sd !== 2'b00) begin miscompares++; $display("FAIL basic_drain got=%b/%0d/%b exp=0/0/00", done_valid, done_idx, done_sd); end
    endtask

    task automatic test_same_cycle();
        set_port(0, 3'd2, 4'd2, 2'b01);
        set_port(1, 3'd2, 4'd2, 2'b10);
        step(); clear_req(); #1;
        vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL same_pending got=%b exp=0100", pending); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL same_err1 got=%b exp=0", err); end
        step();
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd2 || done_sd !== 2'b11) begin miscompares++; $display("FAIL same_done got=%b/%0d/%b exp=1/2/11", done_valid, done_idx, done_sd); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL same_err2 got=%b exp=0", err); end
        step();
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL same_single got=%b exp=0", done_valid); end
    endtask

    task automatic test_backpressure();
        done_ready = 1'b0;
        set_port(0, 3'd0, 4'd1, 2'b01);
        set_port(1, 3'd3, 4'd1, 2'b10);
        step(); #1; // cycle 1, request lines still driven to look at ready
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready got=%b exp=00", req_ready); end
        req_valid = '0;
        vectors++; if (pending !== 4'b1001) begin miscompares++; $display("FAIL bp_pending1 got=%b exp=1001", pending); end
        step(); // cycle 2
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd0 || done_sd !== 2'b01) begin miscompares++; $display("FAIL bp_first got=%b/%0d/%b exp=1/0/01", done_valid, done_idx, done_sd); end
        vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL bp_pending2 got=%b exp=1000", pending); end
        vectors++; if (req_ready[1] !== 1'b0) begin miscompares++; $display("FAIL bp_ready3 got=%b exp=0", req_ready[1]); end
        step(); // cycle 3
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd0 || done_sd !== 2'b01) begin miscompares++; $display("FAIL bp_hold got=%b/%0d/%b exp=1/0/01", done_valid, done_idx, done_sd); end
        done_ready = 1'b1;
        step(); // cycle 4
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd3 || done_sd !== 2'b10) begin miscompares++; $display("FAIL bp_second got=%b/%0d/%b exp=1/3/10", done_valid, done_idx, done_sd); end
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL bp_pending3 got=%b exp=0000", pending); end
        clear_req();
        step(); // cycle 5
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got=%b exp=0", done_valid); end
    endtask

    task automatic test_errors();
        set_port(0, 3'd0, 4'd3, 2'b01);
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b0 || pending !== 4'b0001) begin miscompares++; $display("FAIL err_first got=%b/%b exp=0/0001", err, pending); end
        set_port(0, 3'd0, 4'd2, 2'b10); // target mismatch
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_mismatch got=%b exp=1", err); end
        vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL err_mm_pending got=%b exp=0001", pending); end
        set_port(0, 3'd0, 4'd3, 2'b01);
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_len got=%b exp=0", err); end
        step(); // entry at cnt=2 of 3: nothing should come out
        vectors++; if (done_valid !== 1'b0 || pending !== 4'b0001) begin miscompares++; $display("FAIL err_cnt_kept got=%b/%b exp=0/0001", done_valid, pending); end
        set_port(1, 3'd0, 4'd3, 2'b01);
        step(); clear_req(); #1;
        step();
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd0 || done_sd !== 2'b01) begin miscompares++; $display("FAIL err_sd_unmerged got=%b/%0d/%b exp=1/0/01", done_valid, done_idx, done_sd); end
        step();
        // out-of-range index
        set_port(0, 3'd5, 4'd1, 2'b11); #1;
        vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL oor_ready got=%b exp=1", req_ready[0]); end
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b1 || pending !== 4'b0000) begin miscompares++; $display("FAIL oor_err got=%b/%b exp=1/0000", err, pending); end
        // zero target on an idle entry
        set_port(1, 3'd1, 4'd0, 2'b01);
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b1 || pending !== 4'b0000) begin miscompares++; $display("FAIL zero_tgt got=%b/%b exp=1/0000", err, pending); end
        step();
        vectors++; if (err !== 1'b0 || done_valid !== 1'b0) begin miscompares++; $display("FAIL err_quiet got=%b/%b exp=0/0", err, done_valid); end
    endtask

    task automatic test_overshoot();
        set_port(0, 3'd3, 4'd2, 2'b01);
        step(); clear_req(); #1;
        set_port(0, 3'd3, 4'd2, 2'b10);
        set_port(1, 3'd3, 4'd2, 2'b00);
        step(); clear_req(); #1;
        vectors++; if (err !== 1'b1 || pending !== 4'b1000) begin miscompares++; $display("FAIL over_err got=%b/%b exp=1/1000", err, pending); end
        step();
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd3 || done_sd !== 2'b11) begin miscompares++; $display("FAIL over_fire got=%b/%0d/%b exp=1/3/11", done_valid, done_idx, done_sd); end
        step();
    endtask

    task automatic test_back_to_back();
        set_port(0, 3'd2, 4'd1, 2'b10);
        step(); #1; // cycle 1: entry 2 FIRED, request held
        vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_bp got=%b exp=0", req_ready[0]); end
        step(); // cycle 2: entry freed, same request now accepted
        vectors++; if (req_ready[0] !== 1'b1 || done_valid !== 1'b1 || done_idx !== 3'd2) begin miscompares++; $display("FAIL b2b_free got=%b/%b/%0d exp=1/1/2", req_ready[0], done_valid, done_idx); end
        step(); clear_req(); #1; // cycle 3
        vectors++; if (pending !== 4'b0100 || err !== 1'b0) begin miscompares++; $display("FAIL b2b_rearm got=%b/%b exp=0100/0", pending, err); end
        step(); // cycle 4
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd2 || done_sd !== 2'b10) begin miscompares++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/2/10", done_valid, done_idx, done_sd); end
        step();
    endtask

    task automatic test_mid_reset();
        done_ready = 1'b0;
        set_port(0, 3'd0, 4'd1, 2'b01);
        set_port(1, 3'd1, 4'd3, 2'b01);
        step(); clear_req(); #1; // cycle 1
        step(); // cycle 2
        vectors++; if (done_valid !== 1'b1 || pending !== 4'b0010) begin miscompares++; $display("FAIL mr_pre got=%b/%b exp=1/0010", done_valid, pending); end
        rst = 1'b1;
        step(); // cycle 3
        vectors++; if (pending !== 4'b0000 || done_valid !== 1'b0 || done_idx !== 3'd0 || done_sd !== 2'b00) begin miscompares++; $display("FAIL mr_cleared got=%b/%b/%0d/%b exp=0000/0/0/00", pending, done_valid, done_idx, done_sd); end
        rst = 1'b0;
        done_ready = 1'b1;
        set_port(0, 3'd1, 4'd1, 2'b10);
        step(); clear_req(); #1; // cycle 4
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL mr_fresh_pending got=%b exp=0010", pending); end
        step(); // cycle 5
        vectors++; if (done_valid !== 1'b1 || done_idx !== 3'd1 || done_sd !== 2'b10) begin miscompares++; $display("FAIL mr_fresh_done got=%b/%0d/%b exp=1/1/10", done_valid, done_idx, done_sd); end
        step();
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL mr_no_stale got=%b exp=0", done_valid); end
    endtask

    initial begin
        rst = 1'b1;
        done_ready = 1'b1;
        clear_req();
        #1;
        test_reset();
        test_two_arrivals();
        test_same_cycle();
        test_backpressure();
        test_errors();
        test_overshoot();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
